// File: rtl/pl_stage_chain.sv
// -----------------------------------------------------------------------------
// pl_stage_chain
//
// Purpose:
//    A generic in-order pipeline register chain with per-stage stall and flush
//    controls, automatic bubble insertion behind a stalled stage, and two
//    saturating event counters (bubble cycles, flush cycles). Stage 0 is the
//    youngest stage; stage STAGES-1 is the oldest. Invalid stages always carry
//    an all-zero payload, so downstream decode treats them as a nop.
//
// Parameters:
//    WIDTH   payload bits per stage
//    STAGES  number of pipeline register stages (intended range 2..8)
//    CNT_W   width of the event counters
//
// Ports:
//    clk         in   clock; all state updates on the rising edge
//    reset       in   asynchronous, active-high reset
//    in_data     in   payload entering stage 0
//    in_valid    in   in_data is a real instruction
//    in_ready    out  stage 0 accepts in_data this cycle
//    stall       in   bit i requests a hold of stage i
//    flush       in   bit i kills the contents of stage i
//    out_data    out  stage i payload at bits [i*WIDTH +: WIDTH]
//    out_valid   out  bit i = stage i holds a real instruction
//    bubble_cnt  out  cycles in which at least one bubble was inserted
//    flush_cnt   out  cycles in which any flush bit was set
// -----------------------------------------------------------------------------
module pl_stage_chain #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [STAGES-1:0]         stall,
   input  logic [STAGES-1:0]         flush,
   output logic [STAGES*WIDTH-1:0]   out_data,
   output logic [STAGES-1:0]         out_valid,
   output logic [CNT_W-1:0]          bubble_cnt,
   output logic [CNT_W-1:0]          flush_cnt
);

   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] bubble;
   logic [CNT_W-1:0]  bub_cnt_q;
   logic [CNT_W-1:0]  bub_cnt_d;
   logic [CNT_W-1:0]  fl_cnt_q;
   logic [CNT_W-1:0]  fl_cnt_d;

   // Counter increment that sticks at the all-ones value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // A stall in any older stage freezes this stage too, so hold[i] is the OR
   // of stall[STAGES-1:i].
   always_comb begin
      hold = '0;
      for (int i = 0; i < STAGES; i++) begin
         hold[i] = |(stall >> i);
      end
   end

   always_comb begin
      valid_d = valid_q;
      bubble  = '0;
      for (int i = 0; i < STAGES; i++) begin
         data_d[i] = data_q[i];
      end

      // Stage 0: flush wins over hold; otherwise load from the input port,
      // forcing a zero payload for non-instructions.
      if (flush[0]) begin
         valid_d[0] = 1'b0;
         data_d[0]  = '0;
      end else if (!hold[0]) begin
         valid_d[0] = in_valid;
         data_d[0]  = in_valid ? in_data : '0;
      end

      // Older stages: a free stage directly behind a held one cannot take the
      // held contents, so it receives a nop bubble. A flushed bubble slot
      // counts only as a flush.
      for (int i = 1; i < STAGES; i++) begin
         if (flush[i]) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
         end else if (!hold[i]) begin
            if (hold[i-1]) begin
               valid_d[i] = 1'b0;
               data_d[i]  = '0;
               bubble[i]  = 1'b1;
            end else begin
               valid_d[i] = valid_q[i-1];
               data_d[i]  = data_q[i-1];
            end
         end
      end

      // One count per cycle regardless of how many stages bubble or flush.
      bub_cnt_d = (|bubble) ? sat_inc(bub_cnt_q) : bub_cnt_q;
      fl_cnt_d  = (|flush)  ? sat_inc(fl_cnt_q)  : fl_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= '0;
         bub_cnt_q <= '0;
         fl_cnt_q  <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         bub_cnt_q <= bub_cnt_d;
         fl_cnt_q  <= fl_cnt_d;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   always_comb begin
      out_data = '0;
      for (int i = 0; i < STAGES; i++) begin
         out_data[i*WIDTH +: WIDTH] = data_q[i];
      end
   end

   assign in_ready   = ~hold[0];
   assign out_valid  = valid_q;
   assign bubble_cnt = bub_cnt_q;
   assign flush_cnt  = fl_cnt_q;

endmodule

// File: tb/tb_pl_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pl_stage_chain
//
// Purpose:
//    Self-checking bench for pl_stage_chain (WIDTH=8, STAGES=4, CNT_W=4).
//    Payloads accepted at stage 0 are queued as expected stage-3 outputs and
//    compared when stage 3 produces them; stall, flush, bubble, counter and
//    reset behaviour is checked against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pl_stage_chain;

   localparam int W  = 8;
   localparam int S  = 4;
   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic [S-1:0]   stall;
   logic [S-1:0]   flush;
   logic [S*W-1:0] out_data;
   logic [S-1:0]   out_valid;
   logic [CW-1:0]  bubble_cnt;
   logic [CW-1:0]  flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] sb_q[$];

   always #5 clk = ~clk;

   pl_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .stall      (stall),
      .flush      (flush),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .bubble_cnt (bubble_cnt),
      .flush_cnt  (flush_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a real instruction at stage 0; caller guarantees it is accepted.
   task automatic feed(input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      sb_q.push_back(d);
   endtask

   // One clock; sample 1 time unit after the edge. Stage 3 produced a new
   // result if it is valid and was not held during that edge.
   task automatic tick();
      logic held3;
      logic [W-1:0] e;
      held3 = stall[S-1];
      @(posedge clk);
      #1;
      if (out_valid[S-1] && !held3) begin
         check_eq("sb_pending", (sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("stage3_out", out_data[(S-1)*W +: W], e);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      stall    = '0;
      flush    = '0;
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_bub", bubble_cnt, 0);
      check_eq("rst_fl", flush_cnt, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Streaming 0x11..0x44; 1-cycle latency into stage 0, 4 to stage 3.
      for (int k = 0; k < 4; k++) begin
         feed(8'h11 * (k + 1));
         tick();
         if (k == 0) begin
            check_eq("lat1_data", out_data[W-1:0], 8'h11);
            check_eq("lat1_valid", out_valid, 4'b0001);
         end
      end
      check_eq("full_data", out_data, 32'h11223344);
      check_eq("full_valid", out_valid, 4'b1111);

      // Stall stage 1: stages 0,1 hold, stage 2 bubbles, stage 3 takes 0x22.
      in_valid = 1'b0;
      in_data  = '0;
      stall    = 4'b0010;
      #1;
      check_eq("stall_in_ready", in_ready, 0);
      tick();
      check_eq("stall_data", out_data, 32'h22003344);
      check_eq("stall_valid", out_valid, 4'b1011);
      check_eq("stall_bub", bubble_cnt, 1);
      check_eq("stall_fl", flush_cnt, 0);

      // Flush beats stall on stages 0,1; stage 2 still bubbles.
      flush = 4'b0011;
      tick();
      check_eq("fl_data", out_data, 0);
      check_eq("fl_valid", out_valid, 0);
      check_eq("fl_bub", bubble_cnt, 2);
      check_eq("fl_fl", flush_cnt, 1);
      sb_q.delete();

      // A bubble slot that is also flushed counts only as a flush.
      stall = 4'b0001;
      flush = 4'b0010;
      tick();
      check_eq("bubfl_bub", bubble_cnt, 2);
      check_eq("bubfl_fl", flush_cnt, 2);
      stall = '0;
      flush = '0;

      // Refill, then stall the oldest stage for 3 cycles: everything freezes.
      for (int k = 0; k < 4; k++) begin
         feed(8'hA1 + k);
         tick();
      end
      check_eq("refill_data", out_data, 32'hA1A2A3A4);
      stall    = 4'b1000;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("old_in_ready", in_ready, 0);
         tick();
         check_eq("old_data", out_data, 32'hA1A2A3A4);
         check_eq("old_valid", out_valid, 4'b1111);
         check_eq("old_bub", bubble_cnt, 2);
      end
      stall    = '0;
      in_valid = 1'b0;
      in_data  = '0;
      for (int k = 0; k < 3; k++) tick();
      check_eq("drain_valid", out_valid, 4'b1000);
      check_eq("drain_sb", sb_q.size(), 0);

      // Asynchronous reset asserted mid-cycle while data is in flight.
      feed(8'hB1);
      tick();
      feed(8'hB2);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_data", out_data, 0);
      check_eq("mid_rst_bub", bubble_cnt, 0);
      check_eq("mid_rst_fl", flush_cnt, 0);
      check_eq("mid_rst_ready", in_ready, 1);
      sb_q.delete();
      reset = 1'b0;
      feed(8'hC1);
      tick();
      check_eq("resume_data", out_data[W-1:0], 8'hC1);
      check_eq("resume_valid", out_valid, 4'b0001);
      in_valid = 1'b0;
      in_data  = '0;
      for (int k = 0; k < 3; k++) tick();
      check_eq("resume_sb", sb_q.size(), 0);

      // Saturation: stage 1 bubbles every cycle, counter sticks at 15.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      stall = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         tick();
         check_eq("sat_bub", bubble_cnt, (k > 15) ? 15 : k);
      end
      check_eq("sat_in_ready", in_ready, 0);
      check_eq("sat_fl", flush_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pl_stage_chain.md
PL_STAGE_CHAIN -- requirements
Module: pl_stage_chain

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, meaning payload bits per stage.
REQ-002 SHALL provide parameter STAGES, default 4, meaning number of pipeline register stages; legal range 2..8.
REQ-003 SHALL provide parameter CNT_W, default 16, meaning width of the event counters.
REQ-004 SHALL provide port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port in_data  input  WIDTH  payload entering stage 0.
REQ-007 SHALL provide port in_valid  input  1  in_data is a real instruction.
REQ-008 SHALL provide port in_ready  output  1  stage 0 accepts in_data this cycle.
REQ-009 SHALL provide port stall  input  STAGES  bit i requests hold of stage i.
REQ-010 SHALL provide port flush  input  STAGES  bit i kills stage i contents.
REQ-011 SHALL provide port out_data  output  STAGES*WIDTH  stage i payload at bits [i*WIDTH +: WIDTH].
REQ-012 SHALL provide port out_valid  output  STAGES  bit i = stage i holds a real instruction.
REQ-013 SHALL provide port bubble_cnt  output  CNT_W  count of cycles in which a bubble was inserted.
REQ-014 SHALL provide port flush_cnt  output  CNT_W  count of cycles in which any flush bit was set.

Function
REQ-015 SHALL treat stage 0 as the youngest stage (IF/ID); stage i loads from stage i-1; stage STAGES-1 is the oldest.
REQ-016 SHALL compute hold[i] = OR of stall[j] for all j >= i (an older stall freezes all younger stages).
REQ-017 SHALL drive in_ready = ~hold[0], combinationally.
REQ-018 SHALL, on each edge, give per-stage priority: flush[i] > hold[i] > bubble > load.
REQ-019 SHALL, on flush[i], set out_valid[i]=0 and zero the stage i payload, regardless of stall.
REQ-020 SHALL, on hold[i] without flush[i], keep stage i payload and valid unchanged.
REQ-021 SHALL, for i>0 when hold[i]=0 and hold[i-1]=1, insert a bubble: valid 0, payload all-zero (nop).
REQ-022 SHALL, for i>0 when not held and no bubble, copy payload and valid from stage i-1 (latency 1 cycle per stage).
REQ-023 SHALL, for stage 0 when not held, load valid<=in_valid and payload<=in_valid ? in_data : 0.
REQ-024 SHALL keep every invalid stage payload at all-zero so downstream control decodes as nop.
REQ-025 SHALL increment bubble_cnt by exactly 1 in any cycle where at least one bubble is inserted (not per stage), saturating at 2^CNT_W-1.
REQ-026 SHALL increment flush_cnt by 1 in any cycle with flush != 0, saturating at 2^CNT_W-1.
REQ-027 SHALL, for a bubble stage that is also flushed, count only the flush (bubble_cnt unchanged for that stage's contribution).
REQ-028 SHALL have a full in-to-oldest latency of STAGES cycles with no stalls.

Reset
REQ-029 SHALL, while reset=1, immediately (without a clock edge) force all payloads to 0, out_valid to 0, and both counters to 0.
REQ-030 SHALL resume normal loading on the first rising edge after reset deasserts; in_ready=1 during reset when stall=0.

Verification
REQ-031 SHALL cover reset: assert reset mid-stream between edges -> out_valid=0, out_data=0, and counters=0 before the next edge.
REQ-032 SHALL cover streaming: STAGES=4, WIDTH=8, in_valid=1 with data 0x11,0x22,0x33,0x44 on consecutive edges -> stage 3 = 0x11, valid on the 4th edge, then 0x22, 0x33, 0x44.
REQ-033 SHALL cover stall: full pipe 0x44/0x33/0x22/0x11 with stall=4'b0010 for one cycle -> stages 0,1 hold 0x44/0x33; stage 2 becomes a bubble (0x00, valid 0); stage 3 = 0x22; in_ready=0; bubble_cnt +1.
REQ-034 SHALL cover flush vs stall: stall=4'b0010 with flush=4'b0011 on the same cycle -> stages 0,1 valid 0 and payload 0x00; stage 2 bubble; flush_cnt +1; bubble_cnt +1.
REQ-035 SHALL cover oldest-stage stall: stall=4'b1000 for 3 cycles -> all stages frozen; no bubble; bubble_cnt unchanged; in_ready=0 for those 3 cycles.
REQ-036 SHALL cover saturation: CNT_W=4, stall=4'b0001 for 20 cycles -> bubble_cnt reaches 15 and stays at 15.
